// File: rtl/wave_source_pkg.sv
// ---------------------------------------------------------------------------
// wave_source_pkg
//   Types and widths that the triangle-wave source and its step helper share.
//   WS_IW : signed internal width. It holds V +/- S for any 16-bit A and S
//           without overflow.
//   WS_AW : width of the amplitude and step inputs.
// ---------------------------------------------------------------------------
package wave_source_pkg;

    localparam int WS_IW = 18;
    localparam int WS_AW = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RISE = 2'd1,
        FALL = 2'd2
    } ws_state_t;

    typedef logic signed [WS_IW-1:0] ws_val_t;

    // Run configuration. It is captured on leaving IDLE and frozen for the whole run.
    typedef struct packed {
        logic [WS_AW-1:0] amp;
        logic [WS_AW-1:0] step;
    } ws_cfg_t;

    // Zero-extends an unsigned 16-bit quantity into the signed internal domain.
    function automatic ws_val_t ws_widen(input logic [WS_AW-1:0] x);
        return ws_val_t'({{(WS_IW-WS_AW){1'b0}}, x});
    endfunction

endpackage

// File: rtl/ws_clamp_step.sv
// ---------------------------------------------------------------------------
// ws_clamp_step
//   Combinational next-sample calculator for the triangle wave.
//   Ports:
//     v       : current sample (signed, internal width)
//     s       : step magnitude (non-negative)
//     a       : peak magnitude (non-negative)
//     falling : 1 = moving toward -a, 0 = moving toward +a
//     v_next  : next sample, clamped to +/-a at the peaks
//     turn    : 1 when the clamp was hit and the direction must flip
// ---------------------------------------------------------------------------
module ws_clamp_step
    import wave_source_pkg::*;
(
    input  ws_val_t v,
    input  ws_val_t s,
    input  ws_val_t a,
    input  logic    falling,
    output ws_val_t v_next,
    output logic    turn
);

    ws_val_t sum;
    ws_val_t diff;
    ws_val_t neg_a;

    always_comb begin
        sum    = v + s;
        diff   = v - s;
        neg_a  = -a;
        v_next = sum;
        turn   = 1'b0;
        if (falling) begin
            v_next = diff;
            // Use <= so that landing exactly on -a also counts as the peak.
            if (diff <= neg_a) begin
                v_next = neg_a;
                turn   = 1'b1;
            end
        end else if (sum >= a) begin
            v_next = a;
            turn   = 1'b1;
        end
    end

endmodule

// File: rtl/wave_source.sv
// ---------------------------------------------------------------------------
// wave_source
//   Triangle-wave generator with an AXI-Stream master output. Once enabled,
//   it emits 0 and then ramps by +/-S between +A and -A. It advances one
//   sample per accepted beat.
//   Ports:
//     SYS_aclk      : clock, rising edge
//     SYS_reset     : synchronous, active-high reset
//     WS_enable     : run request. Dropping it ends the run after the current beat
//     WS_amplitude  : peak magnitude A, sampled only when leaving IDLE
//     WS_step       : per-beat increment S, sampled only when leaving IDLE
//     M_AXIS_tready : downstream ready
//     M_AXIS_tvalid : sample valid
//     M_AXIS_tdata  : signed sample, sign-extended to AXIS_TDATA_WIDTH
//     M_AXIS_tuser  : sign-change mark. Present only with WS_SIGN_MARK_EN
//   Build option:
//     WS_SIGN_MARK_EN : adds M_AXIS_tuser and the sign-history register.
//   AXIS_TDATA_WIDTH must be at least 18.
// ---------------------------------------------------------------------------
module wave_source
    import wave_source_pkg::*;
#(
    parameter int AXIS_TDATA_WIDTH = 32
) (
    input  logic                        SYS_aclk,
    input  logic                        SYS_reset,
    input  logic                        WS_enable,
    input  logic [WS_AW-1:0]            WS_amplitude,
    input  logic [WS_AW-1:0]            WS_step,
    input  logic                        M_AXIS_tready,
    output logic                        M_AXIS_tvalid,
`ifdef WS_SIGN_MARK_EN
    output logic                        M_AXIS_tuser,
`endif
    output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata
);

    ws_state_t state_q, state_d;
    ws_val_t   v_q, v_d;
    logic      vld_q, vld_d;
    ws_cfg_t   cfg_q, cfg_d;

    ws_val_t   v_next;
    logic      turn;
    logic      accept;

`ifdef WS_SIGN_MARK_EN
    // Sign of the last accepted beat. hist_vld_q is clear until the first
    // beat of a run has been accepted, so that beat is never marked.
    logic      hist_vld_q, hist_vld_d;
    logic      hist_neg_q, hist_neg_d;
`endif

    assign accept = vld_q & M_AXIS_tready;

    ws_clamp_step u_step (
        .v       (v_q),
        .s       (ws_widen(cfg_q.step)),
        .a       (ws_widen(cfg_q.amp)),
        .falling (state_q == FALL),
        .v_next  (v_next),
        .turn    (turn)
    );

    always_comb begin
        state_d = state_q;
        v_d     = v_q;
        vld_d   = vld_q;
        cfg_d   = cfg_q;
`ifdef WS_SIGN_MARK_EN
        hist_vld_d = hist_vld_q;
        hist_neg_d = hist_neg_q;
`endif
        case (state_q)
            IDLE: begin
                vld_d = 1'b0;
                v_d   = '0;
`ifdef WS_SIGN_MARK_EN
                hist_vld_d = 1'b0;
                hist_neg_d = 1'b0;
`endif
                if (WS_enable) begin
                    cfg_d   = '{amp: WS_amplitude, step: WS_step};
                    state_d = RISE;
                    vld_d   = 1'b1;
                end
            end
            RISE, FALL: begin
                // Nothing moves while the beat is stalled. A dropped enable
                // takes effect only when the current beat is accepted.
                if (accept) begin
                    if (!WS_enable) begin
                        state_d = IDLE;
                        vld_d   = 1'b0;
                        v_d     = '0;
`ifdef WS_SIGN_MARK_EN
                        hist_vld_d = 1'b0;
                        hist_neg_d = 1'b0;
`endif
                    end else begin
                        v_d = v_next;
                        if (turn)
                            state_d = (state_q == RISE) ? FALL : RISE;
`ifdef WS_SIGN_MARK_EN
                        hist_vld_d = 1'b1;
                        hist_neg_d = v_q[WS_IW-1];
`endif
                    end
                end
            end
            default: begin
                state_d = IDLE;
                vld_d   = 1'b0;
                v_d     = '0;
            end
        endcase
    end

    always_ff @(posedge SYS_aclk) begin
        if (SYS_reset) begin
            state_q <= IDLE;
            v_q     <= '0;
            vld_q   <= 1'b0;
            cfg_q   <= '0;
`ifdef WS_SIGN_MARK_EN
            hist_vld_q <= 1'b0;
            hist_neg_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            v_q     <= v_d;
            vld_q   <= vld_d;
            cfg_q   <= cfg_d;
`ifdef WS_SIGN_MARK_EN
            hist_vld_q <= hist_vld_d;
            hist_neg_q <= hist_neg_d;
`endif
        end
    end

    assign M_AXIS_tvalid = vld_q;
    // v_q is signed, so the size cast sign-extends it.
    assign M_AXIS_tdata  = AXIS_TDATA_WIDTH'(v_q);
`ifdef WS_SIGN_MARK_EN
    // tuser is derived from registered state only, so it holds through a stall.
    assign M_AXIS_tuser  = hist_vld_q & (hist_neg_q ^ v_q[WS_IW-1]);
`endif

endmodule

// File: tb/tb_wave_source.sv
module tb_wave_source;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [15:0]   amp;
    logic [15:0]   step;
    logic          ready;
    logic          vld;
    logic [W-1:0]  data;
`ifdef WS_SIGN_MARK_EN
    logic          user;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    wave_source #(.AXIS_TDATA_WIDTH(W)) dut (
        .SYS_aclk      (clk),
        .SYS_reset     (rst),
        .WS_enable     (en),
        .WS_amplitude  (amp),
        .WS_step       (step),
        .M_AXIS_tready (ready),
        .M_AXIS_tvalid (vld),
`ifdef WS_SIGN_MARK_EN
        .M_AXIS_tuser  (user),
`endif
        .M_AXIS_tdata  (data)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int sdata();
        return int'($signed(data));
    endfunction

    task automatic chk_beat(input string name, input int exp_v, input bit exp_u, input bit exp_vld);
        chk({name, ".tvalid"}, int'(vld), int'(exp_vld));
        chk({name, ".tdata"}, sdata(), exp_v);
`ifdef WS_SIGN_MARK_EN
        chk({name, ".tuser"}, int'(user), int'(exp_u));
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    // ---------------- reference model: whole-run sample list ----------------
    int mq[128];
    bit mu[128];

    function automatic void build(input int a, input int s);
        int  v = 0;
        bit  up = 1;
        mq[0] = 0;
        mu[0] = 0;
        for (int k = 1; k < 128; k++) begin
            if (up) begin
                v = v + s;
                if (v >= a) begin v = a; up = 0; end
            end else begin
                v = v - s;
                if (v <= -a) begin v = -a; up = 1; end
            end
            mq[k] = v;
            mu[k] = (mq[k] < 0) != (mq[k-1] < 0);
        end
    endfunction

    // ---------------- table vectors ----------------
    typedef struct {
        int a;
        int s;
        int n;
        int exp[24];
    } vec_t;

    vec_t tbl[6];

    initial begin
        bit u;
        rst = 1'b1; en = 1'b0; amp = '0; step = '0; ready = 1'b0;

        tbl[0] = '{63, 10, 24, '{0,10,20,30,40,50,60,63,53,43,33,23,13,3,-7,-17,-27,-37,-47,-57,-63,-53,-43,-33}};
        tbl[1] = '{5, 20, 5, '{0,5,-5,5,-5,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0}};
        tbl[2] = '{0, 7, 4, '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0}};
        tbl[3] = '{100, 0, 4, '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0}};
        tbl[4] = '{65535, 65535, 6, '{0,65535,0,-65535,0,65535,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0}};
        tbl[5] = '{7, 3, 10, '{0,3,6,7,4,1,-2,-5,-7,-4,0,0,0,0,0,0,0,0,0,0,0,0,0,0}};

        // reset state
        tick(); tick();
        chk_beat("reset", 0, 0, 0);
        rst = 1'b0;

        // table runs
        for (int i = 0; i < 6; i++) begin
            do_reset();
            amp = 16'(tbl[i].a); step = 16'(tbl[i].s); en = 1'b1; ready = 1'b1;
            for (int k = 0; k < tbl[i].n; k++) begin
                tick();
                u = (k == 0) ? 1'b0 : ((tbl[i].exp[k] < 0) != (tbl[i].exp[k-1] < 0));
                chk_beat($sformatf("tbl%0d.b%0d", i, k), tbl[i].exp[k], u, 1'b1);
            end
            en = 1'b0;
            tick();
            chk_beat($sformatf("tbl%0d.stop", i), 0, 0, 0);
        end

        // stall at 40 for 5 cycles
        do_reset();
        amp = 16'd63; step = 16'd10; en = 1'b1; ready = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk_beat("stall.hold", 40, 0, 1);
        end
        ready = 1'b1;
        tick();
        chk_beat("stall.next", 50, 0, 1);

        // enable dropped during stall at 30
        do_reset();
        amp = 16'd63; step = 16'd10; en = 1'b1; ready = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        ready = 1'b0; en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_beat("dis.hold", 30, 0, 1);
        end
        ready = 1'b1;
        tick();
        chk_beat("dis.idle", 0, 0, 0);
        en = 1'b1;
        tick();
        chk_beat("dis.restart", 0, 0, 1);
        tick();
        chk_beat("dis.restart2", 10, 0, 1);

        // reset during stall at -27
        do_reset();
        amp = 16'd63; step = 16'd10; en = 1'b1; ready = 1'b1;
        for (int k = 0; k < 17; k++) tick();
        ready = 1'b0;
        tick();
        chk_beat("rst.stalled", -27, 0, 1);
        rst = 1'b1;
        tick();
        chk_beat("rst.cleared", 0, 0, 0);
        rst = 1'b0; en = 1'b0;
        tick();
        chk_beat("rst.idle", 0, 0, 0);

        // amplitude change mid-run is ignored until the next run
        do_reset();
        amp = 16'd63; step = 16'd10; en = 1'b1; ready = 1'b1;
        tick();
        chk_beat("amp.b0", 0, 0, 1);
        amp = 16'd10;
        for (int k = 1; k < 10; k++) begin
            tick();
            chk_beat($sformatf("amp.b%0d", k), tbl[0].exp[k], 0, 1);
        end
        en = 1'b0;
        tick();
        chk_beat("amp.idle", 0, 0, 0);
        en = 1'b1;
        tick(); chk_beat("amp.r0", 0, 0, 1);
        tick(); chk_beat("amp.r1", 10, 0, 1);
        tick(); chk_beat("amp.r2", 0, 0, 1);
        tick(); chk_beat("amp.r3", -10, 1, 1);

        // randomized runs against the list model
        for (int r = 0; r < 25; r++) begin
            int  ba, bs, idx;
            bit  m_vld;
            do_reset();
            case ($urandom_range(0, 3))
                0: begin ba = $urandom_range(0, 20);    bs = $urandom_range(0, 10);    end
                1: begin ba = $urandom_range(0, 300);   bs = $urandom_range(0, 80);    end
                2: begin ba = $urandom_range(0, 65535); bs = $urandom_range(0, 65535); end
                default: begin
                    ba = $urandom_range(1, 1000);
                    bs = 2 * ba + $urandom_range(0, 50);
                end
            endcase
            m_vld = 1'b0;
            idx   = 0;
            for (int c = 0; c < 80; c++) begin
                en    = (c < 55) ? ($urandom_range(0, 19) != 0) : 1'b0;
                ready = ($urandom_range(0, 3) != 0);
                rst   = ($urandom_range(0, 149) == 0);
                if ($urandom_range(0, 3) == 0) begin
                    amp  = 16'($urandom_range(0, 65535));
                    step = 16'($urandom_range(0, 65535));
                end else begin
                    amp  = 16'(ba);
                    step = 16'(bs);
                end
                @(posedge clk);
                if (rst) m_vld = 1'b0;
                else if (!m_vld) begin
                    if (en) begin
                        build(int'(amp), int'(step));
                        idx   = 0;
                        m_vld = 1'b1;
                    end
                end else if (ready) begin
                    if (!en) m_vld = 1'b0;
                    else idx++;
                end
                #1;
                chk_beat($sformatf("rnd%0d.c%0d", r, c),
                         m_vld ? mq[idx] : 0, m_vld ? mu[idx] : 1'b0, m_vld);
            end
            rst = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/wave_source.md
WAVE_SOURCE -- requirements
Module: wave_source

Interface
REQ-001 SHALL have parameter AXIS_TDATA_WIDTH, default 32, output sample width in bits (min 18).
REQ-002 SHALL have port SYS_aclk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port SYS_reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port WS_enable  input  1  run request.
REQ-005 SHALL have port WS_amplitude  input  16  unsigned peak magnitude A.
REQ-006 SHALL have port WS_step  input  16  unsigned per-beat increment S.
REQ-007 SHALL have port M_AXIS_tready  input  1  downstream ready.
REQ-008 SHALL have port M_AXIS_tvalid  output  1  sample valid.
REQ-009 SHALL have port M_AXIS_tdata  output  AXIS_TDATA_WIDTH  signed two's-complement sample, sign-extended.
REQ-010 SHALL have port M_AXIS_tuser  output  1  sign-change mark; present only with WS_SIGN_MARK_EN.

Function
REQ-011 SHALL implement FSM states IDLE, RISE, FALL.
REQ-012 IDLE: tvalid=0; internal value V=0; on WS_enable=1, SHALL latch A and S, enter RISE, and assert tvalid with tdata=0 next cycle.
REQ-013 Beat accepted iff tvalid=1 and tready=1; each accepted beat SHALL present the next sample on the following cycle, giving 1 beat/cycle at tready=1.
REQ-014 RISE next value: V+S; if result >= A, SHALL output A and move to FALL.
REQ-015 FALL next value: V-S; if result <= -A, SHALL output -A and move to RISE.
REQ-016 Arithmetic SHALL use signed 18-bit internal width (no overflow for 16-bit A, S) and sign-extend to AXIS_TDATA_WIDTH.
REQ-017 tvalid=1 and tready=0: tdata, tuser, state SHALL hold stable; tvalid SHALL NOT drop.
REQ-018 WS_amplitude/WS_step changes SHALL be ignored outside IDLE.
REQ-019 WS_enable=0 while running: current beat SHALL complete its handshake; on that handshake, SHALL go to IDLE with tvalid=0 the next cycle and V=0.
REQ-020 A=0 or S=0: output SHALL be constant 0 while enabled.
REQ-021 S >= 2A (A>0): output SHALL alternate A, -A after the initial 0.
REQ-022 tuser SHALL be 1 on a beat whose sample sign (negative vs non-negative) differs from the previously accepted beat, else 0; first beat after IDLE SHALL be 0.

Reset
REQ-023 SYS_reset=1 SHALL, at next edge, force IDLE, tvalid=0, tdata=0, tuser=0, V=0, sign history cleared, regardless of handshake in progress.
REQ-024 Reset asserted mid-stall SHALL drop tvalid without a handshake.

Configuration
REQ-025 Macro WS_SIGN_MARK_EN defined: M_AXIS_tuser port and sign-history register SHALL exist per REQ-022.
REQ-026 Macro undefined: port and sign-history logic SHALL be absent; all other behaviour identical.

Structure
REQ-027 Package wave_source_pkg SHALL hold the FSM state enum, internal width constant (18), and amplitude/step width constant (16).
REQ-028 Sub-module ws_clamp_step SHALL compute next value and turn flag (combinational: V, S, A, direction -> V', turn).

Verification
REQ-029 A=63, S=10, tready=1: tdata 0,10,20,30,40,50,60,63,53,43,33,23,13,3,-7,...,-57,-63,-53; tuser=1 only on -7 and on first non-negative beat after.
REQ-030 Same config, tready held 0 for 5 cycles at tdata=40: tdata=40 and tvalid=1 throughout; next accepted beat 50.
REQ-031 A=5, S=20: tdata 0,5,-5,5,-5; tuser 0,0,1,1,1.
REQ-032 WS_enable dropped while tready=0 at tdata=30: tvalid stays 1 until handshake, then 0; re-enable restarts at 0.
REQ-033 SYS_reset pulsed at tdata=-27 during stall: next cycle tvalid=0, tdata=0, tuser=0.
REQ-034 WS_amplitude changed 63->10 mid-run: sequence unchanged until IDLE; next run peaks at 10.
